// File: rtl/alu_pkg.sv
// Shared encodings for the ALU time-share arbiter: FSM states, ALU SELECT codes
// and SHIFT_TYPE values.
package alu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StBusy = 2'd1;
    localparam state_t StDone = 2'd2;

    localparam logic [2:0] AluSelFwd   = 3'b000;
    localparam logic [2:0] AluSelAdd   = 3'b001;
    localparam logic [2:0] AluSelAnd   = 3'b010;
    localparam logic [2:0] AluSelOr    = 3'b011;
    localparam logic [2:0] AluSelShift = 3'b100;

    localparam logic ShtLeft  = 1'b0;
    localparam logic ShtRight = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; prio_i names the port that wins a tie.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = prio_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALU between the CPU control path (port 0) and an auxiliary
// engine (port 1): grant, hold operands for SETTLE_CYCLES edges, capture, pulse DONE.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic [DATA_WIDTH-1:0] A0,
    input  logic [DATA_WIDTH-1:0] B0,
    input  logic [DATA_WIDTH-1:0] A1,
    input  logic [DATA_WIDTH-1:0] B1,
    input  logic [2:0]            SEL0,
    input  logic [2:0]            SEL1,
    input  logic                  SHT0,
    input  logic                  SHT1,
    output logic                  DONE0,
    output logic                  DONE1,
    output logic [DATA_WIDTH-1:0] RES,
    output logic                  ZFLAG,
    output logic [1:0]            GNT,
    output logic [DATA_WIDTH-1:0] ALU_DATA1,
    output logic [DATA_WIDTH-1:0] ALU_DATA2,
    output logic [2:0]            ALU_SELECT,
    output logic                  ALU_SHIFT_TYPE,
    input  logic [DATA_WIDTH-1:0] ALU_RESULT,
    input  logic                  ALU_ZERO
);

    localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            done_q, done_d;
    logic                  prio_q, prio_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d;
    logic [DATA_WIDTH-1:0] data2_q, data2_d;
    logic [2:0]            sel_q, sel_d;
    logic                  sht_q, sht_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  zflag_q, zflag_d;
    logic [1:0]            arb_gnt;

    rr_arbiter2 u_rr_arbiter2 (
        .req_i  ({REQ1, REQ0}),
        .prio_i (prio_q),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        prio_d  = prio_q;
        data1_d = data1_q;
        data2_d = data2_q;
        sel_d   = sel_q;
        sht_d   = sht_q;
        res_d   = res_q;
        zflag_d = zflag_q;

        unique case (state_q)
            StIdle: begin
                if (|arb_gnt) begin
                    gnt_d   = arb_gnt;
                    cnt_d   = SettleInit;
                    state_d = StBusy;
                    if (arb_gnt[1]) begin
                        data1_d = A1;
                        data2_d = B1;
                        sel_d   = SEL1;
                        sht_d   = SHT1;
                    end else begin
                        data1_d = A0;
                        data2_d = B0;
                        sel_d   = SEL0;
                        sht_d   = SHT0;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    res_d   = ALU_RESULT;
                    zflag_d = ALU_ZERO;
                    done_d  = gnt_q;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                // Having served port 0, the next tie goes to port 1, and vice versa.
                prio_d  = gnt_q[0];
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            prio_q  <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
            sel_q   <= 3'b000;
            sht_q   <= 1'b0;
            res_q   <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            prio_q  <= prio_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            sel_q   <= sel_d;
            sht_q   <= sht_d;
            res_q   <= res_d;
            zflag_q <= zflag_d;
        end
    end

    assign DONE0          = done_q[0];
    assign DONE1          = done_q[1];
    assign RES            = res_q;
    assign ZFLAG          = zflag_q;
    assign GNT            = gnt_q;
    assign ALU_DATA1      = data1_q;
    assign ALU_DATA2      = data2_q;
    assign ALU_SELECT     = sel_q;
    assign ALU_SHIFT_TYPE = sht_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU, a scoreboard of expected DONE
// results for the SETTLE=2 instance, and directed timing checks on a SETTLE=1 instance.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic [1:0] port;
        logic [7:0] res;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [2:0] sel0 = '0, sel1 = '0;
    logic       sht0 = 1'b0, sht1 = 1'b0;
    logic       done0, done1, zflag, alu_sht, alu_z;
    logic [7:0] res, alu_d1, alu_d2, alu_res;
    logic [1:0] gnt;
    logic [2:0] alu_sel;

    logic       s1_req0 = 1'b0, s1_req1 = 1'b0;
    logic [7:0] s1_a0 = '0, s1_b0 = '0, s1_a1 = '0, s1_b1 = '0;
    logic [2:0] s1_sel0 = '0, s1_sel1 = '0;
    logic       s1_sht0 = 1'b0, s1_sht1 = 1'b0;
    logic       s1_done0, s1_done1, s1_zflag, s1_alu_sht, s1_alu_z;
    logic [7:0] s1_res, s1_alu_d1, s1_alu_d2, s1_alu_res;
    logic [1:0] s1_gnt;
    logic [2:0] s1_alu_sel;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   prev_done = -1;
    int   gap_exp = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    function automatic logic [7:0] alu_f(input logic [7:0] d1, input logic [7:0] d2,
                                         input logic [2:0] sel, input logic sht);
        case (sel)
            AluSelFwd:   return d2;
            AluSelAdd:   return d1 + d2;
            AluSelAnd:   return d1 & d2;
            AluSelOr:    return d1 | d2;
            AluSelShift: return (sht == ShtRight) ? (d1 >> 1) : (d1 << 1);
            default:     return d1 ^ d2;
        endcase
    endfunction

    assign alu_res    = alu_f(alu_d1, alu_d2, alu_sel, alu_sht);
    assign alu_z      = (alu_res == 8'h00);
    assign s1_alu_res = alu_f(s1_alu_d1, s1_alu_d2, s1_alu_sel, s1_alu_sht);
    assign s1_alu_z   = (s1_alu_res == 8'h00);

    alu_share_arbiter #(.SETTLE_CYCLES(2), .DATA_WIDTH(8)) u_dut (
        .CLK(clk), .RESET(rst), .REQ0(req0), .REQ1(req1),
        .A0(a0), .B0(b0), .A1(a1), .B1(b1), .SEL0(sel0), .SEL1(sel1),
        .SHT0(sht0), .SHT1(sht1), .DONE0(done0), .DONE1(done1), .RES(res),
        .ZFLAG(zflag), .GNT(gnt), .ALU_DATA1(alu_d1), .ALU_DATA2(alu_d2),
        .ALU_SELECT(alu_sel), .ALU_SHIFT_TYPE(alu_sht), .ALU_RESULT(alu_res),
        .ALU_ZERO(alu_z)
    );

    alu_share_arbiter #(.SETTLE_CYCLES(1), .DATA_WIDTH(8)) u_dut1 (
        .CLK(clk), .RESET(rst), .REQ0(s1_req0), .REQ1(s1_req1),
        .A0(s1_a0), .B0(s1_b0), .A1(s1_a1), .B1(s1_b1), .SEL0(s1_sel0),
        .SEL1(s1_sel1), .SHT0(s1_sht0), .SHT1(s1_sht1), .DONE0(s1_done0),
        .DONE1(s1_done1), .RES(s1_res), .ZFLAG(s1_zflag), .GNT(s1_gnt),
        .ALU_DATA1(s1_alu_d1), .ALU_DATA2(s1_alu_d2), .ALU_SELECT(s1_alu_sel),
        .ALU_SHIFT_TYPE(s1_alu_sht), .ALU_RESULT(s1_alu_res), .ALU_ZERO(s1_alu_z)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every DONE pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (!rst && (done0 || done1)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", 32'({done1, done0}), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_port", 32'({done1, done0}), 32'(mon_e.port));
                check("res", 32'(res), 32'(mon_e.res));
                check("zflag", 32'(zflag), 32'(mon_e.z));
                check("gnt_in_done", 32'(gnt), 32'(mon_e.port));
            end
            if (gap_exp != 0 && prev_done >= 0)
                check("done_gap", 32'(cyc - prev_done), 32'(gap_exp));
            prev_done = cyc;
        end
    end

    task automatic drive_port(input int p, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] sel, input logic sht);
        exp_t e;
        if (p == 0) begin
            a0 = a; b0 = b; sel0 = sel; sht0 = sht; req0 = 1'b1;
        end else begin
            a1 = a; b1 = b; sel1 = sel; sht1 = sht; req1 = 1'b1;
        end
        e.port = (p == 0) ? 2'b01 : 2'b10;
        e.res  = alu_f(a, b, sel, sht);
        e.z    = (e.res == 8'h00);
        sb_q.push_back(e);
    endtask

    // One op on an idle DUT with SETTLE=2: grant at edge 0, DONE after edge 2.
    task automatic run_single(input int p, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] sel, input logic sht);
        logic [1:0] g;
        g = (p == 0) ? 2'b01 : 2'b10;
        drive_port(p, a, b, sel, sht);
        @(negedge clk);
        check("gnt_busy", 32'(gnt), 32'(g));
        check("alu_data1", 32'(alu_d1), 32'(a));
        check("alu_select", 32'(alu_sel), 32'(sel));
        check("done_early", 32'({done1, done0}), 32'd0);
        repeat (2) @(negedge clk);
        check("done_at_settle", 32'({done1, done0}), 32'(g));
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("gnt_idle", 32'(gnt), 32'd0);
        check("done_cleared", 32'({done1, done0}), 32'd0);
    endtask

    task automatic wait_dones(input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(negedge clk);
            if (done0 || done1) seen++;
        end
        check("dones_seen", 32'(seen), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        check("rst_outputs", 32'({done1, done0, gnt, zflag}), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_alu", 32'({alu_d1, alu_d2, alu_sel, alu_sht}), 32'd0);
        check("rst_s1_outputs", 32'({s1_done0, s1_gnt, s1_res}), 32'd0);
        rst = 1'b0;

        run_single(0, 8'h05, 8'h03, AluSelAdd, ShtLeft);
        run_single(1, 8'hFF, 8'h01, AluSelAdd, ShtLeft);
        run_single(0, 8'h81, 8'h00, AluSelShift, ShtRight);
        run_single(1, 8'h81, 8'h00, AluSelShift, ShtLeft);
        run_single(0, 8'h5A, 8'h0F, 3'b110, ShtLeft);

        // Contention from reset: grants alternate starting with port 0.
        rst = 1'b1;
        a0 = 8'hF0; b0 = 8'h3C; sel0 = AluSelAnd; sht0 = ShtLeft; req0 = 1'b1;
        a1 = 8'hF0; b1 = 8'h0F; sel1 = AluSelOr; sht1 = ShtLeft; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.port = (i % 2 == 0) ? 2'b01 : 2'b10;
            e.res  = (i % 2 == 0) ? 8'h30 : 8'hFF;
            e.z    = 1'b0;
            sb_q.push_back(e);
        end
        prev_done = -1;
        gap_exp = 4;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("contend_first_gnt", 32'(gnt), 32'd1);
        wait_dones(4, 30);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        gap_exp = 0;
        check("contend_gnt_idle", 32'(gnt), 32'd0);

        // Operand change and request withdrawal after grant.
        drive_port(0, 8'h05, 8'h03, AluSelAdd, ShtLeft);
        @(negedge clk);
        check("wd_gnt", 32'(gnt), 32'd1);
        a0 = 8'h7F;
        req0 = 1'b0;
        @(negedge clk);
        check("wd_alu_data1_held", 32'(alu_d1), 32'h05);
        @(negedge clk);
        check("wd_done0", 32'(done0), 32'd1);
        check("wd_res", 32'(res), 32'h08);
        @(negedge clk);
        check("wd_gnt_idle", 32'(gnt), 32'd0);
        @(negedge clk);
        check("wd_no_regrant", 32'({done0, gnt}), 32'd0);

        // Reset during BUSY abandons the op.
        a1 = 8'h12; b1 = 8'h34; sel1 = AluSelAdd; sht1 = ShtLeft; req1 = 1'b1;
        @(negedge clk);
        check("rm_gnt_busy", 32'(gnt), 32'd2);
        rst = 1'b1;
        #1;
        check("rm_outputs_zero", 32'({done1, done0, gnt, zflag}), 32'd0);
        check("rm_res_zero", 32'(res), 32'd0);
        check("rm_alu_zero", 32'({alu_d1, alu_d2, alu_sel, alu_sht}), 32'd0);
        @(negedge clk);
        check("rm_no_done", 32'({done1, done0}), 32'd0);
        rst = 1'b0;
        drive_port(1, 8'h12, 8'h34, AluSelAdd, ShtLeft);
        @(negedge clk);
        check("rm_regrant", 32'(gnt), 32'd2);
        check("rm_alu_data2", 32'(alu_d2), 32'h34);
        wait_dones(1, 10);
        req1 = 1'b0;
        @(negedge clk);
        check("rm_gnt_idle", 32'(gnt), 32'd0);

        // SETTLE_CYCLES=1 instance: 3 cycles per op back-to-back.
        s1_a0 = 8'h11; s1_b0 = 8'hA5; s1_sel0 = AluSelFwd; s1_req0 = 1'b1;
        @(negedge clk);
        check("s1_gnt", 32'(s1_gnt), 32'd1);
        check("s1_done_early", 32'(s1_done0), 32'd0);
        @(negedge clk);
        check("s1_done0", 32'(s1_done0), 32'd1);
        check("s1_res", 32'(s1_res), 32'hA5);
        check("s1_zflag", 32'(s1_zflag), 32'd0);
        @(negedge clk);
        check("s1_idle", 32'({s1_done0, s1_gnt}), 32'd0);
        @(negedge clk);
        check("s1_regrant", 32'(s1_gnt), 32'd1);
        @(negedge clk);
        check("s1_done0_again", 32'(s1_done0), 32'd1);
        s1_req0 = 1'b0;
        @(negedge clk);
        check("s1_final_idle", 32'({s1_done0, s1_done1, s1_gnt}), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
